// File: rtl/alu_arbiter_if.sv
// Request/response bundle between two ALU requesters and the arbiter.
// The master modport is the requester side; the slave modport is the arbiter.
interface alu_arbiter_if #(parameter int WIDTH = 17);
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [WIDTH-1:0] req_x0, req_y0, req_x1, req_y1;
  logic [5:0]       req_op0, req_op1;
  logic [1:0]       rsp_valid;
  logic [1:0]       rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_zr, rsp_ng;
  logic             busy;

  modport master (
    output req_valid, req_x0, req_y0, req_op0, req_x1, req_y1, req_op1, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_zr, rsp_ng, busy
  );

  modport slave (
    input  req_valid, req_x0, req_y0, req_op0, req_x1, req_y1, req_op1, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_zr, rsp_ng, busy
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Flow per op: accept in IDLE, compute in EXEC, hold the response in RESP.
module alu_arbiter_alu #(parameter int WIDTH = 17) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [5:0]       op,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             ng
);
  logic [WIDTH-1:0] xz, xn, yz, yn, fo;

  // op = {zx,nx,zy,ny,f,no}
  assign xz  = op[5] ? '0 : x;
  assign xn  = op[4] ? ~xz : xz;
  assign yz  = op[3] ? '0 : y;
  assign yn  = op[2] ? ~yz : yz;
  assign fo  = op[1] ? (xn + yn) : (xn & yn);
  assign out = op[0] ? ~fo : fo;
  assign zr  = (out == '0);
  assign ng  = out[WIDTH-1];
endmodule

module alu_arbiter #(parameter int WIDTH = 17) (
  input  logic         clk,
  input  logic         rst,
  alu_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [5:0]       op;
  } op_req_t;

  state_t           state, state_nxt;
  op_req_t          cur, sel;
  logic             last_grant, gid, gnt, acc;
  logic [WIDTH-1:0] alu_out;
  logic             alu_zr, alu_ng;

  // Sole requester wins; on a tie the one not served last time wins.
  always_comb begin
    gnt = bus.req_valid[1];
    if (&bus.req_valid) gnt = ~last_grant;
  end

  always_comb begin
    sel = '{x: bus.req_x0, y: bus.req_y0, op: bus.req_op0};
    if (gnt) sel = '{x: bus.req_x1, y: bus.req_y1, op: bus.req_op1};
  end

  assign acc           = (state == IDLE) && !rst && bus.req_valid[gnt];
  assign bus.req_ready = {acc && gnt, acc && !gnt};
  assign bus.rsp_valid = (state == RESP) ? {gid, ~gid} : 2'b00;
  assign bus.busy      = (state != IDLE);

  alu_arbiter_alu #(.WIDTH(WIDTH)) u_alu (
    .x   (cur.x),
    .y   (cur.y),
    .op  (cur.op),
    .out (alu_out),
    .zr  (alu_zr),
    .ng  (alu_ng)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (acc) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (bus.rsp_ready[gid]) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      last_grant     <= 1'b1;
      gid            <= 1'b0;
      cur            <= '0;
      bus.rsp_result <= '0;
      bus.rsp_zr     <= 1'b0;
      bus.rsp_ng     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (acc) begin
        cur <= sel;
        gid <= gnt;
      end
      if (state == EXEC) begin
        bus.rsp_result <= alu_out;
        bus.rsp_zr     <= alu_zr;
        bus.rsp_ng     <= alu_ng;
      end
      // Fairness pointer only advances once the response is consumed.
      if (state == RESP && bus.rsp_ready[gid]) last_grant <= gid;
    end
  end
endmodule
